// File: rtl/entropy_block_ctrl_if.sv
// entropy_block_ctrl_if
//   Bundles every signal of the entropy block controller except clk/rst.
//   slave  : the controller's view (consumes the bit stream and decoder results,
//            produces decoder strobes and coefficients).
//   master : the environment's view (bit source, Huffman decoder, coefficient sink).
//
//   start           begin one 8x8 block (sampled only while idle)
//   bit_in/valid    serial entropy-coded stream, bit_ready is the back-pressure
//   dec_ac_dc_flag  table select for the decoder (1 = DC, 0 = AC)
//   dec_next_bit    code bit forwarded to the decoder
//   dec_is_new      strobe: dec_next_bit is a fresh code bit
//   dec_s_value     run length from the decoder
//   dec_r_value     magnitude size from the decoder
//   dec_done        decoder has recognised a complete code
//   coef_value      signed 12-bit coefficient
//   coef_index      zigzag index 0..63
//   coef_valid      coef_value/coef_index are valid this cycle
//   block_done      one-cycle pulse at the end of a block (normal or error)
//   error           sticky error flag, cleared by rst or the next start
interface entropy_block_ctrl_if;
  logic               start;
  logic               bit_in;
  logic               bit_valid;
  logic               bit_ready;
  logic               dec_ac_dc_flag;
  logic               dec_next_bit;
  logic               dec_is_new;
  logic [3:0]         dec_s_value;
  logic [3:0]         dec_r_value;
  logic               dec_done;
  logic signed [11:0] coef_value;
  logic [5:0]         coef_index;
  logic               coef_valid;
  logic               block_done;
  logic               error;

  modport slave (
    input  start, bit_in, bit_valid, dec_s_value, dec_r_value, dec_done,
    output bit_ready, dec_ac_dc_flag, dec_next_bit, dec_is_new,
           coef_value, coef_index, coef_valid, block_done, error
  );

  modport master (
    output start, bit_in, bit_valid, dec_s_value, dec_r_value, dec_done,
    input  bit_ready, dec_ac_dc_flag, dec_next_bit, dec_is_new,
           coef_value, coef_index, coef_valid, block_done, error
  );
endinterface

// File: rtl/entropy_block_ctrl.sv
// entropy_block_ctrl
//   Sequences the decoding of one JPEG-style 8x8 block from a serial entropy
//   coded bit stream. Code bits are forwarded to an external Huffman decoder;
//   the returned (run, size) pairs drive magnitude collection, zero runs and the
//   end-of-block fill. Coefficients leave one per cycle in zigzag order. The DC
//   predictor persists across blocks and is cleared only by rst.
//
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  entropy_block_ctrl_if.slave (stream, decoder and coefficient signals)
module entropy_block_ctrl (
  input  logic                 clk,
  input  logic                 rst,
  entropy_block_ctrl_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, DC_CODE, DC_MAG, AC_CODE, AC_MAG, ZRUN, EOB_FILL, DONE, ERR
  } state_t;

  state_t      state, state_next;
  logic [4:0]  code_cnt, code_cnt_next;
  logic [3:0]  r_lat, r_lat_next;
  logic [10:0] mag, mag_next;
  logic [3:0]  mag_cnt, mag_cnt_next;
  logic [4:0]  run_cnt, run_cnt_next;
  logic        run_mag, run_mag_next;
  logic [5:0]  idx, idx_next;
  logic [11:0] pred, pred_next;

  logic        emit;
  logic [11:0] emit_value;
  logic        error_next;
  logic        done_next;
  logic        ready_c;
  logic        in_code;
  logic        code_hit;
  logic        xfer;
  logic [15:0] mag_shift;
  logic        mag_msb;
  logic [11:0] mag_val;
  logic [6:0]  ac_zeros, ac_total, ac_last;

  assign in_code  = (state == DC_CODE) || (state == AC_CODE);
  // A done seen with count == 0 is left over from the previous code.
  assign code_hit = in_code && (code_cnt != 5'd0) && bus.dec_done;

  // rst suppresses the handshake so no bit is consumed during reset.
  assign bus.bit_ready      = ready_c && !rst;
  assign xfer               = bus.bit_ready && bus.bit_valid;
  assign bus.dec_is_new     = xfer && in_code;
  assign bus.dec_next_bit   = bus.bit_in;
  assign bus.dec_ac_dc_flag = (state == DC_CODE);

  // Magnitude: values with a leading 0 are negative, v - (2^r - 1).
  assign mag_shift = {4'd0, mag, bus.bit_in};
  assign mag_msb   = mag_shift[r_lat - 4'd1];
  assign mag_val   = mag_msb ? mag_shift[11:0]
                             : mag_shift[11:0] - ((12'd1 << r_lat) - 12'd1);

  // Last index an AC code would touch; used to refuse overflowing runs up front.
  assign ac_zeros = (bus.dec_r_value == 4'd0) ? 7'd16 : {3'd0, bus.dec_s_value};
  assign ac_total = ac_zeros + ((bus.dec_r_value != 4'd0) ? 7'd1 : 7'd0);
  assign ac_last  = {1'b0, idx} + ac_total - 7'd1;

  always_comb begin
    state_next    = state;
    code_cnt_next = code_cnt;
    r_lat_next    = r_lat;
    mag_next      = mag;
    mag_cnt_next  = mag_cnt;
    run_cnt_next  = run_cnt;
    run_mag_next  = run_mag;
    idx_next      = idx;
    pred_next     = pred;
    emit          = 1'b0;
    emit_value    = 12'd0;
    ready_c       = 1'b0;
    error_next    = bus.error;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next    = DC_CODE;
          idx_next      = 6'd0;
          code_cnt_next = 5'd0;
          error_next    = 1'b0;
        end
      end

      DC_CODE, AC_CODE: begin
        if (code_hit) begin
          code_cnt_next = 5'd0;
          r_lat_next    = bus.dec_r_value;
          mag_next      = 11'd0;
          mag_cnt_next  = bus.dec_r_value;
          if (state == DC_CODE) begin
            if (bus.dec_r_value == 4'd0) begin
              emit       = 1'b1;
              emit_value = pred;
              state_next = AC_CODE;
            end else if (bus.dec_r_value <= 4'd11) begin
              state_next = DC_MAG;
            end else begin
              state_next = ERR;
            end
          end else if (bus.dec_r_value == 4'd0 && bus.dec_s_value == 4'd0) begin
            state_next = EOB_FILL;
          end else if ((bus.dec_r_value == 4'd0 && bus.dec_s_value != 4'd15) ||
                       bus.dec_r_value > 4'd10) begin
            state_next = ERR;
          end else if (ac_last > 7'd63) begin
            state_next = ERR;
          end else if (bus.dec_r_value == 4'd0) begin
            state_next   = ZRUN;
            run_cnt_next = 5'd16;
            run_mag_next = 1'b0;
          end else if (bus.dec_s_value == 4'd0) begin
            state_next = AC_MAG;
          end else begin
            state_next   = ZRUN;
            run_cnt_next = {1'b0, bus.dec_s_value};
            run_mag_next = 1'b1;
          end
        end else if (code_cnt == 5'd16) begin
          state_next = ERR;
        end else begin
          ready_c = 1'b1;
          if (xfer) begin
            code_cnt_next = code_cnt + 5'd1;
          end
        end
      end

      DC_MAG, AC_MAG: begin
        ready_c = 1'b1;
        if (xfer) begin
          mag_next     = mag_shift[10:0];
          mag_cnt_next = mag_cnt - 4'd1;
          if (mag_cnt == 4'd1) begin
            emit = 1'b1;
            if (state == DC_MAG) begin
              emit_value = pred + mag_val;
              pred_next  = emit_value;
              state_next = AC_CODE;
            end else begin
              emit_value = mag_val;
              state_next = (idx == 6'd63) ? DONE : AC_CODE;
            end
          end
        end
      end

      ZRUN: begin
        emit         = 1'b1;
        run_cnt_next = run_cnt - 5'd1;
        if (run_cnt == 5'd1) begin
          if (run_mag) begin
            state_next = AC_MAG;
          end else begin
            state_next = (idx == 6'd63) ? DONE : AC_CODE;
          end
        end
      end

      EOB_FILL: begin
        emit = 1'b1;
        if (idx == 6'd63) begin
          state_next = DONE;
        end
      end

      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (emit) begin
      idx_next = idx + 6'd1;
    end
    if (state_next == ERR) begin
      error_next = 1'b1;
    end
    done_next = (state_next == DONE) || (state_next == ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      code_cnt       <= 5'd0;
      r_lat          <= 4'd0;
      mag            <= 11'd0;
      mag_cnt        <= 4'd0;
      run_cnt        <= 5'd0;
      run_mag        <= 1'b0;
      idx            <= 6'd0;
      pred           <= 12'd0;
      bus.coef_valid <= 1'b0;
      bus.coef_value <= 12'sd0;
      bus.coef_index <= 6'd0;
      bus.block_done <= 1'b0;
      bus.error      <= 1'b0;
    end else begin
      state          <= state_next;
      code_cnt       <= code_cnt_next;
      r_lat          <= r_lat_next;
      mag            <= mag_next;
      mag_cnt        <= mag_cnt_next;
      run_cnt        <= run_cnt_next;
      run_mag        <= run_mag_next;
      idx            <= idx_next;
      pred           <= pred_next;
      bus.coef_valid <= emit;
      if (emit) begin
        bus.coef_value <= emit_value;
        bus.coef_index <= idx;
      end
      bus.block_done <= done_next;
      bus.error      <= error_next;
    end
  end

endmodule

// File: tb/tb_entropy_block_ctrl.sv
// tb_entropy_block_ctrl
//   Directed bench for entropy_block_ctrl. A queue-driven bit source feeds the
//   stream, a small decoder model answers (s, r) after a programmed number of
//   code bits, and every emitted coefficient is logged for checking against
//   hand-computed values.
module tb_entropy_block_ctrl;

  logic clk = 1'b0;
  logic rst;

  entropy_block_ctrl_if bus();

  entropy_block_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         len;
    logic [3:0] s;
    logic [3:0] r;
  } code_t;

  logic  bits[$];
  code_t codes[$];
  int    dcnt;
  logic  gaps;
  logic  last_xfer;
  logic  last_new;

  int    log_idx[$];
  int    log_val[$];
  int    ref_idx[$];
  int    ref_val[$];
  logic  done_seen;
  int    done_cnt;
  logic  err_at_done;

  int    vectors;
  int    miscompares;

  task automatic checkOutput(input string tag, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // One clock: absorb the previous edge, log outputs, present the next inputs.
  task automatic applyStimulus(input logic rst_v, input logic start_v);
    @(negedge clk);
    if (last_xfer && bits.size() > 0) begin
      void'(bits.pop_front());
    end
    if (last_new) begin
      bus.dec_done = 1'b0;
      dcnt++;
      if (codes.size() > 0 && dcnt == codes[0].len) begin
        bus.dec_done    = 1'b1;
        bus.dec_s_value = codes[0].s;
        bus.dec_r_value = codes[0].r;
        void'(codes.pop_front());
        dcnt = 0;
      end
    end
    if (bus.coef_valid) begin
      log_idx.push_back(int'(bus.coef_index));
      log_val.push_back(int'($signed(bus.coef_value)));
    end
    if (bus.block_done) begin
      done_seen   = 1'b1;
      done_cnt++;
      err_at_done = bus.error;
    end
    rst       = rst_v;
    bus.start = start_v;
    if (bits.size() > 0) begin
      bus.bit_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.bit_in    = bits[0];
    end else begin
      bus.bit_valid = 1'b0;
      bus.bit_in    = 1'b0;
    end
    #1;
    last_xfer = bus.bit_valid && bus.bit_ready;
    last_new  = bus.dec_is_new;
  endtask

  task automatic push_code(input int len, input int s, input int r);
    code_t c;
    for (int i = 0; i < len; i++) begin
      bits.push_back(1'(i & 1));
    end
    c.len = len;
    c.s   = 4'(s);
    c.r   = 4'(r);
    codes.push_back(c);
  endtask

  task automatic push_mag(input int w, input int v);
    for (int i = w - 1; i >= 0; i--) begin
      bits.push_back(1'((v >> i) & 1));
    end
  endtask

  task automatic flush_source();
    bits.delete();
    codes.delete();
    dcnt      = 0;
    last_xfer = 1'b0;
    last_new  = 1'b0;
  endtask

  task automatic start_block();
    log_idx.delete();
    log_val.delete();
    done_seen = 1'b0;
    done_cnt  = 0;
    applyStimulus(1'b0, 1'b1);
  endtask

  task automatic finish_block(input string tag);
    int n = 0;
    while (!done_seen && n < 1500) begin
      applyStimulus(1'b0, 1'b0);
      n++;
    end
    checkOutput({tag, "_done_seen"}, 32'(done_seen), 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    flush_source();
  endtask

  function automatic int val_at(input int i);
    return (i < log_val.size()) ? log_val[i] : 9999;
  endfunction

  function automatic int idx_at(input int i);
    return (i < log_idx.size()) ? log_idx[i] : 9999;
  endfunction

  function automatic int nonzero_between(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi && i < log_val.size(); i++) begin
      if (log_val[i] != 0) n++;
    end
    return n;
  endfunction

  function automatic int index_breaks();
    int n = 0;
    for (int i = 0; i < log_idx.size(); i++) begin
      if (log_idx[i] != i) n++;
    end
    return n;
  endfunction

  task automatic build_mixed_block();
    push_code(2, 0, 3);  push_mag(3, 3'b101);
    push_code(3, 1, 2);  push_mag(2, 2'b01);
    push_code(4, 0, 10); push_mag(10, 10'b1000000001);
    push_code(2, 3, 5);  push_mag(5, 5'b00111);
    push_code(3, 0, 0);
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    dcnt            = 0;
    gaps            = 1'b0;
    last_xfer       = 1'b0;
    last_new        = 1'b0;
    done_seen       = 1'b0;
    done_cnt        = 0;
    err_at_done     = 1'b0;
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.bit_in      = 1'b0;
    bus.bit_valid   = 1'b0;
    bus.dec_done    = 1'b0;
    bus.dec_s_value = 4'd0;
    bus.dec_r_value = 4'd0;

    // Reset state
    do_reset();
    checkOutput("rst_coef_valid", 32'(bus.coef_valid), 0);
    checkOutput("rst_coef_value", 32'($signed(bus.coef_value)), 0);
    checkOutput("rst_coef_index", 32'(bus.coef_index), 0);
    checkOutput("rst_block_done", 32'(bus.block_done), 0);
    checkOutput("rst_error", 32'(bus.error), 0);
    checkOutput("rst_bit_ready", 32'(bus.bit_ready), 0);

    // DC r=3 bits 010 -> -5, then EOB fills 1..63 with zeros
    push_code(2, 0, 3); push_mag(3, 3'b010); push_code(3, 0, 0);
    start_block();
    finish_block("t1");
    checkOutput("t1_count", log_val.size(), 64);
    checkOutput("t1_dc_index", idx_at(0), 0);
    checkOutput("t1_dc_value", val_at(0), -5);
    checkOutput("t1_ac_nonzero", nonzero_between(1, 63), 0);
    checkOutput("t1_index_seq", index_breaks(), 0);
    checkOutput("t1_error", 32'(err_at_done), 0);
    checkOutput("t1_done_pulses", done_cnt, 1);
    checkOutput("t1_bits_left", bits.size(), 0);

    // Second block: DC r=2 bits 11 -> +3 on predictor -5 -> -2
    push_code(2, 0, 2); push_mag(2, 2'b11); push_code(3, 0, 0);
    start_block();
    finish_block("t2");
    checkOutput("t2_count", log_val.size(), 64);
    checkOutput("t2_dc_value", val_at(0), -2);
    checkOutput("t2_error", 32'(err_at_done), 0);

    // DC r=0 (pred -2), AC s=2 r=1 bit 1, ZRL, EOB
    push_code(2, 0, 0);
    push_code(4, 2, 1); push_mag(1, 1);
    push_code(3, 15, 0);
    push_code(3, 0, 0);
    start_block();
    finish_block("t3");
    checkOutput("t3_count", log_val.size(), 64);
    checkOutput("t3_dc_value", val_at(0), -2);
    checkOutput("t3_val_idx3", val_at(3), 1);
    checkOutput("t3_nonzero", nonzero_between(1, 63), 1);
    checkOutput("t3_idx19", idx_at(19), 19);
    checkOutput("t3_index_seq", index_breaks(), 0);

    // Overflowing run: reach index 50, then s=15 r=1 must error with no emit
    push_code(2, 0, 0);
    push_code(2, 15, 0); push_code(2, 15, 0); push_code(2, 15, 0);
    push_code(3, 0, 1); push_mag(1, 0);
    push_code(3, 15, 1); push_mag(1, 1);
    start_block();
    finish_block("t4");
    flush_source();
    checkOutput("t4_count", log_val.size(), 50);
    checkOutput("t4_last_index", idx_at(49), 49);
    checkOutput("t4_val49", val_at(49), -1);
    checkOutput("t4_error", 32'(err_at_done), 1);
    checkOutput("t4_done_pulses", done_cnt, 1);
    checkOutput("t4_error_sticky", 32'(bus.error), 1);

    // 16 code bits without dec_done -> error; start clears the old error
    push_code(20, 0, 0);
    start_block();
    applyStimulus(1'b0, 1'b0);
    checkOutput("t5_error_cleared", 32'(bus.error), 0);
    finish_block("t5");
    flush_source();
    checkOutput("t5_count", log_val.size(), 0);
    checkOutput("t5_error", 32'(err_at_done), 1);

    // Stall in AC_MAG (missing bits), ignored start, then rst mid-block
    push_code(2, 0, 0);
    push_code(2, 0, 4); push_mag(2, 2'b10);
    start_block();
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t6_stall_count", log_val.size(), 1);
    checkOutput("t6_stall_dc", val_at(0), -2);
    checkOutput("t6_stall_no_done", done_cnt, 0);
    bits.push_back(1'b1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t6_rst_bit_ready", 32'(bus.bit_ready), 0);
    checkOutput("t6_rst_dec_is_new", 32'(bus.dec_is_new), 0);
    applyStimulus(1'b0, 1'b0);
    flush_source();
    checkOutput("t6_coef_valid", 32'(bus.coef_valid), 0);
    checkOutput("t6_coef_value", 32'($signed(bus.coef_value)), 0);
    checkOutput("t6_coef_index", 32'(bus.coef_index), 0);
    checkOutput("t6_block_done", 32'(bus.block_done), 0);
    checkOutput("t6_error", 32'(bus.error), 0);
    push_code(2, 0, 1); push_mag(1, 1); push_code(3, 0, 0);
    start_block();
    finish_block("t6b");
    checkOutput("t6_pred_cleared", val_at(0), 1);
    checkOutput("t6_count", log_val.size(), 64);

    // Mixed block gapless, then again with random bit_valid gaps
    do_reset();
    build_mixed_block();
    gaps = 1'b0;
    start_block();
    finish_block("t7a");
    checkOutput("t7_count", log_val.size(), 64);
    checkOutput("t7_val0", val_at(0), 5);
    checkOutput("t7_val2", val_at(2), -2);
    checkOutput("t7_val3", val_at(3), 513);
    checkOutput("t7_val7", val_at(7), -24);
    checkOutput("t7_nonzero", nonzero_between(1, 63), 3);
    ref_idx = log_idx;
    ref_val = log_val;
    do_reset();
    build_mixed_block();
    gaps = 1'b1;
    start_block();
    finish_block("t7b");
    gaps = 1'b0;
    begin
      int diffs = 0;
      for (int i = 0; i < ref_val.size(); i++) begin
        if (val_at(i) != ref_val[i] || idx_at(i) != ref_idx[i]) diffs++;
      end
      checkOutput("t7_gap_count", log_val.size(), ref_val.size());
      checkOutput("t7_gap_diffs", diffs, 0);
    end

    // Value landing exactly at index 63 ends the block without EOB
    do_reset();
    push_code(2, 0, 0);
    push_code(2, 15, 0); push_code(2, 15, 0); push_code(2, 15, 0);
    push_code(3, 14, 1); push_mag(1, 1);
    start_block();
    finish_block("t8");
    checkOutput("t8_count", log_val.size(), 64);
    checkOutput("t8_idx63", idx_at(63), 63);
    checkOutput("t8_val63", val_at(63), 1);
    checkOutput("t8_nonzero", nonzero_between(1, 62), 0);
    checkOutput("t8_error", 32'(err_at_done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
